// File: rtl/MIPS_DEF.sv
// Shared definitions for the MIPS pipeline.
// Fetch-stage state, step size and the word/PC bundle passed to decode.
package MIPS_DEF;

  localparam int INS_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } ifetch_state_t;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [31:0]      pc;
  } fetch_word_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// IF/ID output slot plus a one-entry skid buffer.
// Absorbs one response that lands while decode is stalled.
module ifetch_buf
  import MIPS_DEF::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  fetch_word_t word,
  output logic        skid_full,
  output fetch_word_t slot,
  output logic        slot_valid
);

  fetch_word_t skid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot       <= '0;
      slot_valid <= 1'b0;
      skid       <= '0;
      skid_full  <= 1'b0;
    end else if (flush) begin
      slot_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (!stall) begin
      if (skid_full) begin
        // older skid word goes out first; a fresh response refills the skid
        slot       <= skid;
        slot_valid <= 1'b1;
        skid_full  <= load;
        if (load) skid <= word;
      end else begin
        slot_valid <= load;
        if (load) slot <= word;
      end
    end else if (load) begin
      if (!slot_valid) begin
        slot       <= word;
        slot_valid <= 1'b1;
      end else begin
        skid      <= word;
        skid_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC, one-outstanding imem handshake,
// redirect/kill handling and the IF/ID output register.
module ifetch_stage
  import MIPS_DEF::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             stall,
  output logic [INS_W-1:0] ins,
  output logic [31:0]      ins_pc,
  output logic             ins_valid
);

  ifetch_state_t state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          skid_full;
  logic          accept;
  logic          deliver;
  fetch_word_t   rsp;
  fetch_word_t   slot;

  assign imem_req  = (state == S_REQ) && !skid_full;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign deliver   = (state == S_WAIT) && imem_rvalid
                   && !redirect_valid;
  assign rsp       = '{ins: imem_rdata, pc: req_pc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ:  state <= accept ? S_DROP : S_REQ;
        S_WAIT: state <= imem_rvalid ? S_REQ : S_DROP;
        // a response landing now retires the killed request
        S_DROP: state <= imem_rvalid ? S_REQ : S_DROP;
      endcase
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc + PC_STEP;
            state  <= S_WAIT;
          end
        end
        S_WAIT: if (imem_rvalid) state <= S_REQ;
        S_DROP: if (imem_rvalid) state <= S_REQ;
      endcase
    end
  end

  ifetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .stall      (stall),
    .load       (deliver),
    .word       (rsp),
    .skid_full  (skid_full),
    .slot       (slot),
    .slot_valid (ins_valid)
  );

  assign ins    = slot.ins;
  assign ins_pc = slot.pc;

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage against an in-order
// expected-PC queue and a latency-programmable memory model.
module tb_ifetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [31:0] q[$];
  logic [31:0] exp_fetch;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat = 1;
  bit          rnd_ready = 1'b0;

  always #5 clk = ~clk;

  ifetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .ins            (ins),
    .ins_pc         (ins_pc),
    .ins_valid      (ins_valid)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // One clock: snapshot pre-edge signals, advance, update model/memory.
  task automatic tick();
    logic        s_rst, s_req, s_rdy, s_rv, s_redir;
    logic        s_stall, s_valid;
    logic [31:0] s_addr, s_rpc, s_ins, s_pc, e;
    s_rst   = rst_n;
    s_req   = imem_req;
    s_rdy   = imem_ready;
    s_rv    = imem_rvalid;
    s_redir = redirect_valid;
    s_stall = stall;
    s_valid = ins_valid;
    s_addr  = imem_addr;
    s_rpc   = redirect_pc;
    s_ins   = ins;
    s_pc    = ins_pc;
    @(negedge clk);
    if (!s_rst) begin
      q.delete();
      exp_fetch   = RESET_PC;
      mem_busy    = 1'b0;
      imem_rvalid = 1'b0;
      chk("rst_valid", 32'(ins_valid), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
    end else begin
      if (s_valid && !s_stall) begin
        if (q.size() == 0) begin
          chk("spurious", 32'(s_valid), 32'd0);
        end else begin
          e = q.pop_front();
          delivered++;
          chk("ins_pc", s_pc, e);
          chk("ins", s_ins, word_of(e));
        end
      end
      if (s_valid && s_stall && !s_redir) begin
        chk("hold_valid", 32'(ins_valid), 32'd1);
        chk("hold_ins", ins, s_ins);
        chk("hold_pc", ins_pc, s_pc);
      end
      if (s_req) chk("fetch_addr", s_addr, exp_fetch);
      if (s_redir) begin
        q.delete();
        exp_fetch = s_rpc & ~32'd3;
        chk("redir_flush", 32'(ins_valid), 32'd0);
      end else if (s_req && s_rdy) begin
        q.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (s_rv) mem_busy = 1'b0;
      if (s_req && s_rdy) begin
        mem_busy = 1'b1;
        mem_cnt  = lat - 1;
        mem_addr = s_addr;
      end else if (mem_busy && mem_cnt > 0) begin
        mem_cnt--;
      end
      imem_rvalid = mem_busy && mem_cnt == 0;
      imem_rdata  = imem_rvalid ? word_of(mem_addr) : $urandom;
    end
    imem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_for(input string tag, input bit on_valid,
                          input int bound);
    int n = 0;
    while (!(on_valid ? ins_valid : imem_req) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(on_valid ? ins_valid : imem_req), 32'd1);
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    exp_fetch      = RESET_PC;
    @(negedge clk);
    tick();
    tick();

    // reset release, latency 1, no stall
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("lat1_valid_c%0d", i), 32'(ins_valid),
          (i == 3 || i == 5 || i == 7) ? 32'd1 : 32'd0);
      if (ins_valid) chk("lat1_pc", ins_pc, 32'((i - 3) * 2));
    end

    // stall 5 cycles: next word parks in the skid
    for (int i = 1; i <= 5; i++) begin
      stall = 1'b1;
      tick();
      if (i >= 2) chk("skid_noreq", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("skid_out_v", 32'(ins_valid), 32'd1);
    chk("skid_out_pc", ins_pc, 32'd12);

    // redirect while 0x8 is outstanding, latency 3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lat = 3;
    for (int n = 0; n < 40; n++) begin
      if (imem_req && imem_addr == 32'd8) break;
      tick();
    end
    chk("reach_8", imem_addr, 32'd8);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    wait_for("wait_req_100", 1'b0, 20);
    chk("redir_addr", imem_addr, 32'h100);
    wait_for("wait_ins_100", 1'b1, 20);
    chk("redir_ins_pc", ins_pc, 32'h100);

    // redirect in the same cycle as an accept
    lat = 1;
    wait_for("wait_req_acc", 1'b0, 20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    chk("drop_noreq", 32'(imem_req), 32'd0);
    chk("drop_pc", imem_addr, 32'h200);
    wait_for("wait_req_200", 1'b0, 20);
    chk("acc_redir_addr", imem_addr, 32'h200);
    wait_for("wait_ins_200", 1'b1, 20);
    chk("acc_redir_pc", ins_pc, 32'h200);

    // wrap-around past the top of the address space
    wait_for("wait_req_wrap", 1'b0, 20);
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_for("wait_req_top", 1'b0, 20);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    wait_for("wait_req_zero", 1'b0, 20);
    chk("wrap_zero", imem_addr, 32'h0);

    // reset with the skid full
    stall = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("full_noreq", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(ins_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);

    // randomized traffic
    rnd_ready = 1'b1;
    delivered = 0;
    for (int i = 0; i < 4000; i++) begin
      lat            = $urandom_range(1, 4);
      stall          = ($urandom % 10) < 3;
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc    = $urandom;
      if (($urandom % 8) == 0) redirect_pc = 32'hFFFF_FFF4;
      rst_n          = ($urandom % 400) != 0;
      tick();
    end
    chk("progress", 32'(delivered > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
